serial_subtractor: RTL and testbench

// - Bit-serial subtractor/comparator for the mini-cpu ALU. Computes A - B LSB-first, one bit per clock.
// - Each bit goes through one full_adder instance with B inverted and an initial carry-in of 1.
// - Produces the difference plus borrow, zero, signed-overflow and less-than flags for branch compares.
// - Sits between the decode stage (operand source) and writeback/branch logic (result sink). Valid/ready both sides.
//

---
 rtl/alu_pkg.sv | 8 +
 rtl/full_adder.sv | 13 +
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: state encodings used by the bit-serial arithmetic units.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the single arithmetic cell reused by the serial ALU units.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B (LSB first, one bit per clock) with borrow/zero/overflow/less-than flags.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow,
  output logic             lt_signed
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] d_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic             a_msb;
  logic             b_msb;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] diff_next;
  logic             ovf_next;

  // Signed overflow of a - b: operands differ in sign and the result's sign differs from a.
  function automatic logic sub_overflow(input logic am, input logic bm, input logic dm);
    return (am != bm) && (dm != am);
  endfunction

  full_adder u_fa (
    .a         (a_sh[0]),
    .b         (~b_sh[0]),
    .carry_in  (carry),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  assign in_ready  = (state == ST_IDLE);
  assign diff_next = {fa_sum, d_sh};
  assign ovf_next  = sub_overflow(a_msb, b_msb, diff_next[WIDTH-1]);

  // Datapath: operand load and per-bit shift; always reloaded before use, so no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= 1'b1;
      count <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == ST_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      d_sh  <= diff_next[WIDTH-1:1];
      carry <= fa_cout;
      count <= count + CW'(1);
    end
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      lt_signed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) state <= ST_RUN;
        end
        ST_RUN: begin
          if (count == LAST) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            diff      <= diff_next;
            borrow    <= ~fa_cout;
            zero      <= ~|diff_next;
            overflow  <= ovf_next;
            lt_signed <= diff_next[WIDTH-1] ^ ovf_next;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): arithmetic reference model plus directed cases.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic bo;
    logic z;
    logic ov;
    logic lt;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         overflow;
  logic         lt_signed;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int accepts = 0;
  int dones = 0;
  res_t q[$];
  bit rst_seen = 1'b0;
  bit prev_ov = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero),
    .overflow  (overflow),
    .lt_signed (lt_signed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    int sx, sy, sd;
    sx = int'($signed(x));
    sy = int'($signed(y));
    sd = sx - sy;
    r.d  = W'(x - y);
    r.bo = (x < y);
    r.z  = (x == y);
    r.ov = (sd > 127) || (sd < -128);
    r.lt = (sx < sy);
    return r;
  endfunction

  function automatic logic [W+3:0] pack(input res_t r);
    return {r.d, r.bo, r.z, r.ov, r.lt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle the result is presented, plus reset and acceptance tracking.
  always @(negedge clk) begin : monitor
    res_t r;
    if (rst_seen) begin
      chk("reset_outputs", {out_valid, diff, borrow, zero, overflow, lt_signed, in_ready},
          {1'b0, 8'h00, 4'h0, 1'b1});
      rst_seen = 1'b0;
    end
    if (!rst_n) begin
      q.delete();
      prev_ov  = 1'b0;
      rst_seen = 1'b1;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          r = q[0];
          chk("result", {diff, borrow, zero, overflow, lt_signed}, pack(r));
          chk("in_ready_busy", in_ready, 0);
          if (!prev_ov) chk("latency", cyc - acc_cyc, 9);
          if (out_ready) begin
            void'(q.pop_front());
            dones++;
          end
        end
      end
      if (in_valid && in_ready) begin
        chk("no_overlap", q.size(), 0);
        q.push_back(model(a, b));
        acc_cyc = cyc;
        accepts++;
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W+3:0] exp);
    chk({name, "_model"}, pack(model(x, y)), exp);
    send(x, y);
    wait_valid();
    chk(name, {diff, borrow, zero, overflow, lt_signed}, exp);
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] corner [4];
    int n, target;
    corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_in_ready", in_ready, 1);

    // Flag order: borrow, zero, overflow, lt_signed
    directed("sub_5_3",   8'h05, 8'h03, {8'h02, 4'b0000});
    directed("sub_3_5",   8'h03, 8'h05, {8'hFE, 4'b1001});
    directed("sub_80_01", 8'h80, 8'h01, {8'h7F, 4'b0011});
    directed("sub_7F_FF", 8'h7F, 8'hFF, {8'h80, 4'b1010});
    directed("sub_A5_A5", 8'hA5, 8'hA5, {8'h00, 4'b0100});

    // Back-to-back: second pair is held on the bus and only taken once IDLE again
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    target = accepts + 2;
    in_valid = 1'b1; a = 8'h3C; b = 8'h5A;
    @(posedge clk); #1;
    chk("b2b_busy", in_ready, 0);
    a = 8'h10; b = 8'h01;
    n = 0;
    while (accepts < target && n < 100) begin @(posedge clk); #1; n++; end
    chk("b2b_second_accept", accepts, target);
    in_valid = 1'b0;
    wait_valid();
    chk("b2b_second_diff", diff, 8'h0F);

    // Backpressure: result held while sink stalls, input activity ignored
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
    send(8'h40, 8'h13);
    wait_valid();
    held = diff;
    chk("bp_diff", held, 8'h2D);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_diff_hold", diff, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_diff_kept", diff, held);

    // Randomized operands with random sink stalls
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x, y;
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      target = dones + 1;
      send(x, y);
      n = 0;
      while (dones < target && n < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
      if (dones < target) chk("random_timeout", 0, 1);
    end
    out_ready = 1'b1;

    // Reset in the 4th RUN cycle discards the operation
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    send(8'h33, 8'h11);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_outputs", {out_valid, diff, borrow, zero, overflow, lt_signed}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    send(8'h09, 8'h02);
    wait_valid();
    chk("after_rst_diff", diff, 8'h07);

    repeat (4) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
